// File: rtl/dbf_pkg.sv
// Shared constants and types for the DBF receive-channel fine-delay stage.
// Widths, FSM state encoding and the pipeline stage records.
package dbf_pkg;

  localparam int INPUT_WD  = 14;
  localparam int FRAC_WD   = 4;
  localparam int FD_OUT_WD = INPUT_WD + 2;
  localparam int ADDR_WD   = 10;
  localparam int LUT_DEPTH = 1 << ADDR_WD;
  localparam int FD_SHIFT  = FRAC_WD - 2;
  localparam int SUM_WD    = INPUT_WD + FRAC_WD + 1;

  typedef enum logic {
    IDLE,
    RUN
  } fd_state_t;

  // S1: registered sample pair awaiting the fraction from the LUT read.
  typedef struct packed {
    logic                       vld;
    logic signed [INPUT_WD-1:0] x;
    logic signed [INPUT_WD-1:0] x_prev;
  } fd_s1_t;

  // S2: the two weighted products.
  typedef struct packed {
    logic                     vld;
    logic signed [SUM_WD-1:0] p_cur;
    logic signed [SUM_WD-1:0] p_prev;
  } fd_s2_t;

endpackage

// File: rtl/fd_lut_ram.sv
// Fine-delay fraction LUT: simple dual-port RAM, one write port, one synchronous read port, no reset.
// Latency 1 cycle read; no backpressure, accepts a read and a write every clock.
module fd_lut_ram #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fine_delay_interp.sv
// Fine delay by linear interpolation x*(2^F-f) + x_prev*f, f per sample from LUT; FD_ROUND_EN adds round-half-up.
// Latency 3 cycles valid-in to valid-out; no backpressure, one sample per clock; leaving RUN flushes the pipe.
module fine_delay_interp
  import dbf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tx_en,
  input  logic [ADDR_WD-1:0]   lut_addr,
  input  logic                 lut_we,
  input  logic [FRAC_WD-1:0]   lut_din,
  input  logic [INPUT_WD-1:0]  fine_din,
  input  logic                 fine_din_valid,
  output logic [FD_OUT_WD-1:0] fine_dout,
  output logic                 fine_dout_valid,
  output logic                 fd_busy
);

`ifdef FD_ROUND_EN
  localparam int RND = 1 << (FRAC_WD - 3);
`else
  localparam int RND = 0;
`endif

  fd_state_t state, state_nxt;
  logic      clr;
  logic      accept;
  logic      lut_wr_en;

  logic [ADDR_WD-1:0]         cnt;
  logic signed [INPUT_WD-1:0] x_prev;
  logic [FRAC_WD-1:0]         frac;

  fd_s1_t s1;
  fd_s2_t s2;

  logic [FRAC_WD:0]         w_cur;
  logic signed [SUM_WD-1:0] x_ext, xp_ext, wc_ext, wp_ext;
  logic signed [SUM_WD-1:0] sum_rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clr covers reset, idling, and the exit edge out of RUN (flush).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !tx_en) state_nxt = RUN;
      RUN:     if (!start || tx_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    clr       = rst || (state_nxt == IDLE);
    accept    = (state == RUN) && (state_nxt == RUN) && fine_din_valid;
    lut_wr_en = lut_we && (state == IDLE);
  end

  fd_lut_ram #(
    .AW (ADDR_WD),
    .DW (FRAC_WD)
  ) u_lut (
    .clk     (clk),
    .wr_en   (lut_wr_en),
    .wr_addr (lut_addr),
    .wr_dat  (lut_din),
    .rd_addr (cnt),
    .rd_dat  (frac)
  );

  // S1: the LUT read at cnt lands together with the captured sample pair.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      x_prev <= '0;
      s1     <= '0;
    end else begin
      s1.vld <= accept;
      if (accept) begin
        s1.x      <= fine_din;
        s1.x_prev <= x_prev;
        x_prev    <= fine_din;
        if (cnt != ADDR_WD'(LUT_DEPTH - 1)) begin
          cnt <= cnt + ADDR_WD'(1);
        end
      end
    end
  end

  always_comb begin
    w_cur  = (FRAC_WD+1)'(1 << FRAC_WD) - {1'b0, frac};
    x_ext  = SUM_WD'($signed(s1.x));
    xp_ext = SUM_WD'($signed(s1.x_prev));
    wc_ext = $signed(SUM_WD'(w_cur));
    wp_ext = $signed(SUM_WD'(frac));
  end

  // S2: weights are non-negative, so zero-extended weights keep the products exact.
  always_ff @(posedge clk) begin
    if (clr) begin
      s2 <= '0;
    end else begin
      s2.vld    <= s1.vld;
      s2.p_cur  <= x_ext * wc_ext;
      s2.p_prev <= xp_ext * wp_ext;
    end
  end

  assign sum_rnd = s2.p_cur + s2.p_prev + SUM_WD'(RND);

  // S3: the shifted sum always fits FD_OUT_WD, so truncation is lossless.
  always_ff @(posedge clk) begin
    if (clr) begin
      fine_dout       <= '0;
      fine_dout_valid <= 1'b0;
    end else begin
      fine_dout_valid <= s2.vld;
      if (s2.vld) begin
        fine_dout <= FD_OUT_WD'(sum_rnd >>> FD_SHIFT);
      end
    end
  end

  assign fd_busy = (state == RUN);

endmodule

// File: doc/fine_delay_interp.md
# fine_delay_interp

Fine-delay stage of one DBF receive channel, placed directly downstream of the coarse delay unit and upstream of apodization. Each valid coarse-delayed sample is delayed by a sub-sample fraction, set per sample from a fine-delay LUT, using linear interpolation between the current and previous samples. The LUT is preloaded through the same address/write-enable bus the coarse LUT uses. The output is a pipelined signed sample carrying two extra fractional bits.

## Interface
- INPUT_WD, 14, coarse-delay sample width (signed)
- FRAC_WD, 4, fine-delay fraction width (unit = 1/2^FRAC_WD sample)
- FD_OUT_WD, 16, output width, fixed = INPUT_WD+2
- ADDR_WD, 10, LUT address width; LUT_DEPTH = 2^ADDR_WD
- clk  in  1  channel clock, 40 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  beamforming active; high for the whole receive line
- tx_en  in  1  transmit window; input is ignored while high
- lut_addr  in  ADDR_WD  LUT write address
- lut_we  in  1  LUT write strobe
- lut_din  in  FRAC_WD  fraction to write
- fine_din  in  INPUT_WD  signed coarse-delayed sample
- fine_din_valid  in  1  sample qualifier
- fine_dout  out  FD_OUT_WD  signed interpolated sample
- fine_dout_valid  out  1  output qualifier
- fd_busy  out  1  high while in RUN state

## Operation
- States:
  - IDLE → RUN when start=1 and tx_en=0.
  - RUN → IDLE when start=0.
  - RUN → IDLE when tx_en=1 (re-arm on the next receive window).
- IDLE:
  - LUT writes are accepted: mem[lut_addr] <= lut_din when lut_we=1.
  - Sample counter = 0, x_prev = 0, pipeline valids = 0.
- RUN:
  - lut_we is ignored (writes are dropped).
  - Each cycle with fine_din_valid=1: read f = mem[cnt], capture x = fine_din, then x_prev <= x and cnt++.
  - cnt saturates at LUT_DEPTH-1; the last fraction is held for the rest of the line.
  - Cycles with fine_din_valid=0 do not advance cnt or x_prev.
- Arithmetic:
  - sum = x·(2^FRAC_WD − f) + x_prev·f, signed, INPUT_WD+FRAC_WD+1 bits.
  - fine_dout = (sum + rnd) >>> (FRAC_WD−2), arithmetic shift. rnd is defined under Configuration.
  - No saturation is needed. The worst-case result lies in [−32768, +32764] for the defaults.
- The first sample after entering RUN interpolates against x_prev = 0.
- Leaving RUN flushes the pipeline: any in-flight samples are dropped, valid goes to 0 and fine_dout goes to 0.
- rst in any state: state=IDLE, cnt=0, x_prev=0, all pipeline registers = 0. LUT contents are not cleared.

## Timing
- Reset values: fine_dout=0, fine_dout_valid=0, fd_busy=0.
- Latency is 3 cycles from fine_din_valid to fine_dout_valid:
  - S1: synchronous LUT read and registered x / x_prev.
  - S2: two products.
  - S3: add, round, shift, output register.
- Full throughput: one sample per clock, no back-pressure.
- fd_busy rises one cycle after the start condition is sampled.
- A LUT write lands one cycle after lut_we and is readable in RUN from the next cycle onward.
- If lut_we and the start edge occur in the same cycle, the write is accepted, because the state is still IDLE.

## Configuration
- FD_ROUND_EN
  - Defined: rnd = 2^(FRAC_WD−3), i.e. round half up.
  - Undefined: rnd = 0, i.e. truncation toward −∞.
- Latency and widths are identical in both builds.

## Structure
- Shared package dbf_pkg holds:
  - the width constants INPUT_WD, FRAC_WD, FD_OUT_WD, ADDR_WD;
  - the state enum (IDLE, RUN);
  - the derived constants LUT_DEPTH and FD_SHIFT = FRAC_WD−2.
- One sub-module, fd_lut_ram: simple dual-port RAM with a synchronous read, one write port and one read port, no reset.
- The interpolation pipeline and FSM live in the top module.

## Test plan
- f=0 for all entries; input 100, 200 → outputs 400, 800, each 3 cycles after its input.
- f=8 for all entries; input 100, 200 → outputs 200, 600.
- f=0; input −8192 → −32768; input 8191 → 32764. Checks that no overflow occurs.
- f=1; input 1 as the first sample → 4 with FD_ROUND_EN defined, 3 without it.
- LUT written 0..15 cyclically; write f=15 at address 0 during RUN → the write is ignored. Feed 1030 samples → cnt holds at 1023 and f stays at 1023 mod 16 = 15.
- tx_en asserted mid-line with 2 samples in flight → valid=0 from the next cycle with no late outputs. The next start restarts from cnt=0 with x_prev=0.
